// File: rtl/router_sync_ctrl.sv
// Port-side controller between the router FSM and the three output FIFOs:
// address latch, write-enable steering, valid outputs and per-port read timeout flush.
module router_sync_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_detect_add,
    input  logic [1:0] i_din,
    input  logic       i_write_enb_reg,
    input  logic       i_read_enb_0,
    input  logic       i_read_enb_1,
    input  logic       i_read_enb_2,
    input  logic       i_empty_0,
    input  logic       i_empty_1,
    input  logic       i_empty_2,
    input  logic       i_full_0,
    input  logic       i_full_1,
    input  logic       i_full_2,
    output logic [2:0] o_write_enb,
    output logic       o_fifo_full,
    output logic       o_vld_out_0,
    output logic       o_vld_out_1,
    output logic       o_vld_out_2,
    output logic       o_soft_reset_0,
    output logic       o_soft_reset_1,
    output logic       o_soft_reset_2
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

    logic [1:0] r_addr;
    logic [2:0] w_read_enb;
    logic [2:0] w_empty;
    logic [2:0] w_full;
    logic [2:0] w_vld;
    logic [2:0] w_soft_reset;
    logic [2:0] w_write_enb;
    logic       w_fifo_full;

    assign w_read_enb = {i_read_enb_2, i_read_enb_1, i_read_enb_0};
    assign w_empty    = {i_empty_2, i_empty_1, i_empty_0};
    assign w_full     = {i_full_2, i_full_1, i_full_0};
    assign w_vld      = ~w_empty;

    // Address 3 is the parked/invalid destination: no FIFO is selected.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_addr <= 2'b11;
        end else if (i_detect_add) begin
            r_addr <= i_din;
        end
    end

    always_comb begin
        w_write_enb = 3'b000;
        if (i_write_enb_reg) begin
            case (r_addr)
                2'd0:    w_write_enb = 3'b001;
                2'd1:    w_write_enb = 3'b010;
                2'd2:    w_write_enb = 3'b100;
                default: w_write_enb = 3'b000;
            endcase
        end
    end

    always_comb begin
        w_fifo_full = 1'b0;
        case (r_addr)
            2'd0:    w_fifo_full = w_full[0];
            2'd1:    w_fifo_full = w_full[1];
            2'd2:    w_fifo_full = w_full[2];
            default: w_fifo_full = 1'b0;
        endcase
    end

    // One independent idle counter per port; the pulse cycle itself resets the count.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_port
            logic [CNT_W-1:0] r_cnt;
            logic             r_soft_reset;

            always_ff @(posedge i_clk) begin
                if (!i_rst) begin
                    r_cnt        <= '0;
                    r_soft_reset <= 1'b0;
                end else if (r_soft_reset || !w_vld[gi] || w_read_enb[gi]) begin
                    r_cnt        <= '0;
                    r_soft_reset <= 1'b0;
                end else if (r_cnt == LP_CNT_LAST) begin
                    r_cnt        <= '0;
                    r_soft_reset <= 1'b1;
                end else begin
                    r_cnt        <= r_cnt + LP_CNT_ONE;
                    r_soft_reset <= 1'b0;
                end
            end

            assign w_soft_reset[gi] = r_soft_reset;
        end
    endgenerate

    assign o_write_enb    = w_write_enb;
    assign o_fifo_full    = w_fifo_full;
    assign o_vld_out_0    = w_vld[0];
    assign o_vld_out_1    = w_vld[1];
    assign o_vld_out_2    = w_vld[2];
    assign o_soft_reset_0 = w_soft_reset[0];
    assign o_soft_reset_1 = w_soft_reset[1];
    assign o_soft_reset_2 = w_soft_reset[2];

endmodule
